// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch, latch, decode, execute and optional memory stage,
// driving datapath strobes from the one-hot opcode decode lines.
module control_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch0,
    input  logic       fetch1,
    input  logic       add_and,
    input  logic       addI,
    input  logic       andI,
    input  logic       nr,
    input  logic       nnd,
    input  logic       jmp,
    input  logic       ld,
    input  logic       st,
    input  logic       comp,
    input  logic       je,
    input  logic       ja,
    input  logic       jb,
    input  logic       jae,
    input  logic       jbe,
    input  logic       funct,
    input  logic       flag_eq,
    input  logic       flag_below,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       imm_sel,
    output logic [2:0] alu_sel,
    output logic       reg_we,
    output logic       wb_sel,
    output logic       flags_we,
    output logic       fault,
    output logic [2:0] state
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned NDEC  = 16;

    localparam int unsigned D_ADD_AND = 2;
    localparam int unsigned D_ADDI    = 3;
    localparam int unsigned D_ANDI    = 4;
    localparam int unsigned D_NR      = 5;
    localparam int unsigned D_NND     = 6;
    localparam int unsigned D_JMP     = 7;
    localparam int unsigned D_LD      = 8;
    localparam int unsigned D_ST      = 9;
    localparam int unsigned D_COMP    = 10;
    localparam int unsigned D_JE      = 11;
    localparam int unsigned D_JA      = 12;
    localparam int unsigned D_JB      = 13;
    localparam int unsigned D_JAE     = 14;
    localparam int unsigned D_JBE     = 15;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_AND  = 3'd1;
    localparam logic [2:0] ALU_NOR  = 3'd2;
    localparam logic [2:0] ALU_NAND = 3'd3;
    localparam logic [2:0] ALU_SUB  = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_LATCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       mem_op_q;    // {st, ld} captured in DECODE
    logic [NDEC-1:0]  dec_in;
    logic             dec_ok;
    logic             accept;
    logic             pending;
    logic             timeout;
    logic             jump_take;
    logic             ld_wb;
    logic             reg_we_q;

    logic       d_mem_req, d_mem_we, d_addr_sel, d_ir_load, d_pc_inc, d_pc_load;
    logic       d_imm_sel, d_reg_we, d_flags_we, d_fault;
    logic [2:0] d_alu_sel;

    assign dec_in = {jbe, jae, jb, ja, je, comp, st, ld,
                     jmp, nnd, nr, andI, addI, add_and, fetch1, fetch0};
    assign dec_ok = (dec_in != '0) && ((dec_in & (dec_in - NDEC'(1))) == '0);

    assign accept  = mem_req & mem_ready;
    assign pending = mem_req & ~mem_ready;
    assign timeout = pending && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    assign jump_take = dec_in[D_JMP]
                     | (dec_in[D_JE]  &  flag_eq)
                     | (dec_in[D_JA]  & ~flag_eq & ~flag_below)
                     | (dec_in[D_JB]  &  flag_below)
                     | (dec_in[D_JAE] & ~flag_below)
                     | (dec_in[D_JBE] & (flag_eq | flag_below));

    // Load writeback must coincide with the memory accept cycle, so it bypasses the output flops
    assign ld_wb  = (state_q == S_MEM) && mem_op_q[0] && accept;
    assign reg_we = reg_we_q | ld_wb;
    assign wb_sel = ld_wb;
    assign state  = state_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (accept) begin
                    state_nxt = S_LATCH;
                end else if (timeout) begin
                    state_nxt = S_FAULT;
                end
            end
            S_LATCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = dec_ok ? S_EXEC : S_FAULT;
            S_EXEC:   state_nxt = (mem_op_q != '0) ? S_MEM : S_FETCH;
            S_MEM: begin
                if (accept) begin
                    state_nxt = S_FETCH;
                end else if (timeout) begin
                    state_nxt = S_FAULT;
                end
            end
            S_FAULT:  state_nxt = S_FAULT;
            default:  state_nxt = S_FAULT;
        endcase
    end

    // Output decode for the state being entered; EXEC is only entered from DECODE, so live lines apply
    always_comb begin
        d_mem_req  = 1'b0;
        d_mem_we   = 1'b0;
        d_addr_sel = 1'b0;
        d_ir_load  = 1'b0;
        d_pc_inc   = 1'b0;
        d_pc_load  = 1'b0;
        d_imm_sel  = 1'b0;
        d_alu_sel  = ALU_ADD;
        d_reg_we   = 1'b0;
        d_flags_we = 1'b0;
        d_fault    = 1'b0;
        unique case (state_nxt)
            S_FETCH: d_mem_req = 1'b1;
            S_LATCH: begin
                d_ir_load = 1'b1;
                d_pc_inc  = 1'b1;
            end
            S_EXEC: begin
                if (dec_in[D_ADD_AND]) begin
                    d_alu_sel = funct ? ALU_AND : ALU_ADD;
                    d_reg_we  = 1'b1;
                end
                if (dec_in[D_ADDI] | dec_in[D_ANDI]) begin
                    d_imm_sel = 1'b1;
                    d_alu_sel = dec_in[D_ANDI] ? ALU_AND : ALU_ADD;
                    d_reg_we  = 1'b1;
                end
                if (dec_in[D_NR] | dec_in[D_NND]) begin
                    d_alu_sel = dec_in[D_NND] ? ALU_NAND : ALU_NOR;
                    d_reg_we  = 1'b1;
                end
                if (dec_in[D_COMP]) begin
                    d_alu_sel  = ALU_SUB;
                    d_flags_we = 1'b1;
                end
                if (dec_in[D_LD] | dec_in[D_ST]) begin
                    d_imm_sel = 1'b1;
                end
                d_pc_load = jump_take;
            end
            S_MEM: begin
                d_mem_req  = 1'b1;
                d_addr_sel = 1'b1;
                d_imm_sel  = 1'b1;
                d_mem_we   = mem_op_q[1];
            end
            S_FAULT: d_fault = 1'b1;
            default: ;
        endcase
    end

    // Registered strobes, decode capture and pending-request counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            addr_sel <= 1'b0;
            ir_load  <= 1'b0;
            pc_inc   <= 1'b0;
            pc_load  <= 1'b0;
            imm_sel  <= 1'b0;
            alu_sel  <= ALU_ADD;
            reg_we_q <= 1'b0;
            flags_we <= 1'b0;
            fault    <= 1'b0;
            mem_op_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_req  <= d_mem_req;
            mem_we   <= d_mem_we;
            addr_sel <= d_addr_sel;
            ir_load  <= d_ir_load;
            pc_inc   <= d_pc_inc;
            pc_load  <= d_pc_load;
            imm_sel  <= d_imm_sel;
            alu_sel  <= d_alu_sel;
            reg_we_q <= d_reg_we;
            flags_we <= d_flags_we;
            fault    <= d_fault;
            if (state_q == S_DECODE) begin
                mem_op_q <= {dec_in[D_ST], dec_in[D_LD]};
            end
            if (accept || (state_nxt != state_q)) begin
                cnt_q <= '0;
            end else if (pending) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected-output sequences built from the
// instruction semantics, checked every cycle, plus literal pulse counts.
module tb_control_sequencer;

    localparam int OP_FETCH0 = 0, OP_FETCH1 = 1, OP_ADD_AND = 2, OP_ADDI = 3, OP_ANDI = 4;
    localparam int OP_NR = 5, OP_NND = 6, OP_JMP = 7, OP_LD = 8, OP_ST = 9, OP_COMP = 10;
    localparam int OP_JE = 11, OP_JA = 12, OP_JB = 13, OP_JAE = 14, OP_JBE = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] dec;
    logic        funct, flag_eq, flag_below, mem_ready;
    logic        mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, imm_sel;
    logic [2:0]  alu_sel;
    logic        reg_we, wb_sel, flags_we, fault;
    logic [2:0]  state;

    typedef struct packed {
        logic [2:0] state;
        logic       fault;
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_load;
        logic       pc_inc;
        logic       pc_load;
        logic       imm_sel;
        logic [2:0] alu_sel;
        logic       reg_we;
        logic       wb_sel;
        logic       flags_we;
    } obs_t;

    obs_t exp_q[$];
    obs_t cmp_e, cmp_o;
    int   total = 0;
    int   bad   = 0;
    int   cyc_no = 0;
    int   n_reg_we, n_pc_inc, n_pc_load, n_wb, n_memaddr, n_mem_we, n_fault, n_fetchreq, n_exec_strobe;

    control_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch0(dec[0]), .fetch1(dec[1]), .add_and(dec[2]), .addI(dec[3]),
        .andI(dec[4]), .nr(dec[5]), .nnd(dec[6]), .jmp(dec[7]),
        .ld(dec[8]), .st(dec[9]), .comp(dec[10]), .je(dec[11]),
        .ja(dec[12]), .jb(dec[13]), .jae(dec[14]), .jbe(dec[15]),
        .funct(funct), .flag_eq(flag_eq), .flag_below(flag_below), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
        .pc_inc(pc_inc), .pc_load(pc_load), .imm_sel(imm_sel), .alu_sel(alu_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .flags_we(flags_we), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    function automatic obs_t dut_obs();
        obs_t o;
        o.state = state;     o.fault = fault;     o.mem_req = mem_req; o.mem_we = mem_we;
        o.addr_sel = addr_sel; o.ir_load = ir_load; o.pc_inc = pc_inc; o.pc_load = pc_load;
        o.imm_sel = imm_sel; o.alu_sel = alu_sel; o.reg_we = reg_we;  o.wb_sel = wb_sel;
        o.flags_we = flags_we;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Expected EXEC-cycle outputs from the instruction semantics
    function automatic obs_t exec_exp(input int op, input logic fn, input logic eq, input logic bl);
        obs_t e = '0;
        e.state = 3'd3;
        case (op)
            OP_ADD_AND: begin e.alu_sel = fn ? 3'd1 : 3'd0; e.reg_we = 1'b1; end
            OP_ADDI:    begin e.imm_sel = 1'b1; e.alu_sel = 3'd0; e.reg_we = 1'b1; end
            OP_ANDI:    begin e.imm_sel = 1'b1; e.alu_sel = 3'd1; e.reg_we = 1'b1; end
            OP_NR:      begin e.alu_sel = 3'd2; e.reg_we = 1'b1; end
            OP_NND:     begin e.alu_sel = 3'd3; e.reg_we = 1'b1; end
            OP_COMP:    begin e.alu_sel = 3'd4; e.flags_we = 1'b1; end
            OP_JMP:     e.pc_load = 1'b1;
            OP_JE:      e.pc_load = eq;
            OP_JA:      e.pc_load = !eq && !bl;
            OP_JB:      e.pc_load = bl;
            OP_JAE:     e.pc_load = !bl;
            OP_JBE:     e.pc_load = eq || bl;
            OP_LD, OP_ST: e.imm_sel = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // Per-cycle compare against the expected queue
    always @(negedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            cmp_o = dut_obs();
            cyc_no++;
            check($sformatf("outs@cyc%0d", cyc_no), 32'(cmp_o), 32'(cmp_e));
            n_reg_we   += int'(cmp_o.reg_we);
            n_pc_inc   += int'(cmp_o.pc_inc);
            n_pc_load  += int'(cmp_o.pc_load);
            n_wb       += int'(cmp_o.wb_sel);
            n_memaddr  += int'(cmp_o.mem_req & cmp_o.addr_sel);
            n_mem_we   += int'(cmp_o.mem_we);
            n_fault    += int'(cmp_o.fault);
            n_fetchreq += int'(cmp_o.mem_req & ~cmp_o.addr_sel);
            n_exec_strobe += int'(cmp_o.reg_we | cmp_o.pc_load | cmp_o.flags_we | cmp_o.imm_sel | cmp_o.mem_we);
        end
    end

    task automatic clr();
        n_reg_we = 0; n_pc_inc = 0; n_pc_load = 0; n_wb = 0; n_memaddr = 0;
        n_mem_we = 0; n_fault = 0; n_fetchreq = 0; n_exec_strobe = 0;
    endtask

    task automatic push(input logic rdy, input obs_t e);
        @(negedge clk);
        mem_ready = rdy;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_outs", 32'(dut_obs()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fetch_to_decode(input int fwait);
        obs_t e = '0;
        e.mem_req = 1'b1;
        for (int i = 0; i < fwait; i++) push(1'b0, e);
        push(1'b1, e);
        e = '0; e.state = 3'd1; e.ir_load = 1'b1; e.pc_inc = 1'b1;
        push(1'b1, e);
        e = '0; e.state = 3'd2;
        push(1'b1, e);
    endtask

    task automatic run_instr(input int op, input logic fn, input logic eq, input logic bl,
                             input int fwait, input int mwait);
        obs_t e;
        dec = 16'(1) << op; funct = fn; flag_eq = eq; flag_below = bl;
        fetch_to_decode(fwait);
        push(1'b1, exec_exp(op, fn, eq, bl));
        if (op == OP_LD || op == OP_ST) begin
            e = '0; e.state = 3'd4; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.imm_sel = 1'b1;
            e.mem_we = (op == OP_ST);
            for (int i = 0; i < mwait; i++) push(1'b0, e);
            if (op == OP_LD) begin e.reg_we = 1'b1; e.wb_sel = 1'b1; end
            push(1'b1, e);
        end
    endtask

    task automatic run_bad(input logic [15:0] d);
        obs_t e = '0;
        dec = d;
        fetch_to_decode(0);
        e.state = 3'd7; e.fault = 1'b1;
        repeat (3) push(1'b1, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t e;
        int cond_ops[5];
        rst_n = 1'b0; dec = '0; funct = 1'b0; flag_eq = 1'b0; flag_below = 1'b0; mem_ready = 1'b0;
        clr();
        do_reset();

        clr();
        repeat (3) run_instr(OP_ADDI, 1'b0, 1'b0, 1'b0, 0, 0);
        settle();
        check("addi_pc_inc_cnt", 32'(n_pc_inc), 32'd3);
        check("addi_reg_we_cnt", 32'(n_reg_we), 32'd3);

        run_instr(OP_ADD_AND, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_ADD_AND, 1'b1, 1'b0, 1'b0, 1, 0);
        run_instr(OP_ANDI,    1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_NR,      1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_NND,     1'b0, 1'b0, 1'b0, 2, 0);
        run_instr(OP_COMP,    1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_JMP,     1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_FETCH0,  1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(OP_FETCH1,  1'b0, 1'b0, 1'b0, 3, 0);

        clr();
        run_instr(OP_LD, 1'b0, 1'b0, 1'b0, 0, 3);
        settle();
        check("ld_memaddr_cycles", 32'(n_memaddr), 32'd4);
        check("ld_reg_we_cnt", 32'(n_reg_we), 32'd1);
        check("ld_wb_cnt", 32'(n_wb), 32'd1);
        clr();
        run_instr(OP_ST, 1'b0, 1'b0, 1'b0, 0, 3);
        settle();
        check("st_memaddr_cycles", 32'(n_memaddr), 32'd4);
        check("st_mem_we_cycles", 32'(n_mem_we), 32'd4);
        check("st_reg_we_cnt", 32'(n_reg_we), 32'd0);
        run_instr(OP_LD, 1'b0, 1'b0, 1'b0, 1, 0);

        clr();
        cond_ops = '{OP_JE, OP_JA, OP_JB, OP_JAE, OP_JBE};
        foreach (cond_ops[k]) begin
            run_instr(cond_ops[k], 1'b0, 1'b1, 1'b0, 0, 0);
            run_instr(cond_ops[k], 1'b0, 1'b0, 1'b1, 0, 0);
            run_instr(cond_ops[k], 1'b0, 1'b0, 1'b0, 0, 0);
        end
        settle();
        check("cond_pc_load_cnt", 32'(n_pc_load), 32'd7);

        clr();
        run_bad(16'h0300);
        settle();
        check("dual_dec_strobes", 32'(n_exec_strobe), 32'd0);
        check("dual_dec_fault_cycles", 32'(n_fault), 32'd3);
        do_reset();
        clr();
        run_bad(16'h0000);
        settle();
        check("zero_dec_strobes", 32'(n_exec_strobe), 32'd0);
        do_reset();

        clr();
        dec = 16'(1) << OP_ADDI;
        e = '0; e.mem_req = 1'b1;
        repeat (4) push(1'b0, e);
        e = '0; e.state = 3'd7; e.fault = 1'b1;
        repeat (3) push(1'b1, e);
        settle();
        check("timeout_pending_cycles", 32'(n_fetchreq), 32'd4);
        check("timeout_fault_cycles", 32'(n_fault), 32'd3);
        do_reset();
        run_instr(OP_ADDI, 1'b0, 1'b0, 1'b0, 0, 0);

        dec = 16'(1) << OP_ST;
        fetch_to_decode(0);
        push(1'b1, exec_exp(OP_ST, 1'b0, 1'b0, 1'b0));
        e = '0; e.state = 3'd4; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.imm_sel = 1'b1; e.mem_we = 1'b1;
        repeat (2) push(1'b0, e);
        @(negedge clk);
        mem_ready = 1'b0;
        #3;
        check("midmem_req_before_rst", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midmem_rst_outs", 32'(dut_obs()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b1;
        rst_n = 1'b1;
        clr();
        run_instr(OP_ADDI, 1'b0, 1'b0, 1'b0, 0, 0);
        settle();
        check("restart_reg_we_cnt", 32'(n_reg_we), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control FSM sitting directly downstream of the 4-bit opcode decoder.
- Consumes the 16 one-hot decode lines, comparison flags and a memory ready handshake.
- Drives PC, IR, register-file, ALU, flag-register and memory strobes.
- Each instruction runs as fetch, decode, execute, then an optional memory stage.

Parameters:
- MEM_TIMEOUT, 16: max cycles mem_req may stay pending before FAULT; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch0, fetch1, add_and, addI, andI, nr, nnd, jmp, ld, st, comp, je, ja, jb, jae, jbe  in  1 each  decoder one-hot lines; fetch0/fetch1 (opcodes 0000/0001) are executed as NOP
- funct  in  1  IR function bit for add_and: 0=ADD, 1=AND
- flag_eq  in  1  stored "equal" flag from flag register
- flag_below  in  1  stored unsigned "below" flag
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  write qualifier; valid only while mem_req=1
- addr_sel  out  1  0=PC, 1=ALU/effective address
- ir_load  out  1  latch memory data into IR
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= jump target
- imm_sel  out  1  ALU B operand from immediate
- alu_sel  out  3  0 ADD, 1 AND, 2 NOR, 3 NAND, 4 SUB (compare)
- reg_we  out  1  register-file write
- wb_sel  out  1  0=ALU result, 1=memory data
- flags_we  out  1  flag-register load
- fault  out  1  sticky error indicator
- state  out  3  current state, for debug

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH.
  - All outputs 0; fault=0.
  - Timeout counter 0.
  - Reset mid-transaction drops mem_req immediately. No write is considered committed.
- State encoding: FETCH=0, LATCH=1, DECODE=2, EXEC=3, MEM=4, FAULT=7.
- Outputs are registered functions of state and latched decode; they are asserted in the state named below.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - On mem_ready=1 go to LATCH; otherwise stay.
- LATCH: ir_load=1, pc_inc=1 for exactly one cycle -> DECODE.
- DECODE:
  - Single settle cycle with no strobes.
  - Samples the 16 decode lines into an internal one-hot register.
  - Zero or more than one line high -> FAULT; otherwise -> EXEC.
- EXEC (one cycle; all strobes single-cycle pulses):
  - add_and: alu_sel=funct?1:0, reg_we=1 -> FETCH
  - addI / andI: imm_sel=1, alu_sel=0 / 1, reg_we=1 -> FETCH
  - nr / nnd: alu_sel=2 / 3, reg_we=1 -> FETCH
  - comp: alu_sel=4, flags_we=1, reg_we=0 -> FETCH
  - jmp: pc_load=1 -> FETCH
  - Conditional jumps: pc_load=1 only when the condition holds, else no strobe; then -> FETCH.
    - je: flag_eq
    - ja: !flag_eq & !flag_below
    - jb: flag_below
    - jae: !flag_below
    - jbe: flag_eq | flag_below
  - ld / st: imm_sel=1, alu_sel=0 (address calc) -> MEM
  - fetch0 / fetch1: no strobe -> FETCH
- MEM:
  - mem_req=1, addr_sel=1, imm_sel=1, alu_sel=0 held stable; mem_we=1 for st.
  - On mem_ready=1:
    - ld: reg_we=1 and wb_sel=1 in that same cycle.
    - st: no writeback.
    - Then -> FETCH.
- Memory handshake:
  - The request is accepted on the cycle mem_ready=1 is sampled with mem_req=1.
  - mem_ready while mem_req=0 is ignored.
  - Back-to-back acceptance is allowed: FETCH can be accepted on its first cycle.
- Timeout:
  - The counter increments on every cycle mem_req=1 and mem_ready=0, and clears on acceptance or on leaving the state.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0 -> FAULT.
- Flag hazard: flags written by comp in EXEC are visible to a following conditional jump. The minimum 4-cycle gap guarantees this; no forwarding.
- FAULT: all strobes 0, fault=1, remains until rst_n asserted.
- Minimum latency (zero-wait memory):
  - ALU/jump instructions: 4 cycles.
  - ld/st: 5 cycles.

Test Plan:
- Reset then release, mem_ready tied 1, decode=addI:
  - FETCH→LATCH→DECODE→EXEC.
  - Exactly one reg_we pulse with imm_sel=1, alu_sel=0.
  - Repeats every 4 cycles; pc_inc pulses once per instruction.
- Decode=ld, mem_ready delayed 3 cycles in MEM:
  - mem_req, addr_sel=1 held for 4 cycles.
  - reg_we=1 with wb_sel=1 only in the accept cycle.
  - Total 8 cycles; for st the same timing with mem_we=1 and no reg_we.
- Conditional jumps, all 5 opcodes × 3 flag combos (eq=1/below=0, eq=0/below=1, eq=0/below=0):
  - pc_load matches the truth table, e.g. ja pulses only for eq=0/below=0.
  - jbe pulses for the first two combos only.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH:
  - Enters FAULT after 4 pending cycles; fault=1, mem_req=0.
  - Holds until rst_n=0 clears everything.
- Decode lines with ld and st both high, and separately all low:
  - FAULT entered from DECODE, no strobe pulse issued.
- Assert rst_n=0 mid-MEM of st while mem_req=1:
  - All outputs 0 asynchronously (same cycle); restart in FETCH after release.
